ripple_count_capture: RTL and testbench

- Downstream consumer of the 4-bit ripple counter output. Brings the raw, asynchronously settling count bits into the `clk` domain.
- Rejects transient codes caused by ripple settling, detects wrap-around, and extends the count with a wrap accumulator.
- Presents each accepted new count value on a valid/ready stream to the next stage.

---
 rtl/ripple_count_capture.sv | 138 +++++++++++++
 tb/tb_ripple_count_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// Capture of a free-running 4-bit ripple counter: synchronize, reject settling glitches,
// extend with a wrap count, and present each new count on a valid/ready stream.
module ripple_count_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int EXT_WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           q_in,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_data,
    output logic                 out_wrap,
    output logic [EXT_WIDTH-1:0] ext_count,
    output logic                 overrun
);

    localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int WCNT_W = EXT_WIDTH - 4;
    localparam int SYNC_W = 4 * SYNC_STAGES;
    localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(STABLE_CYCLES);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
        return (v < SCNT_FULL) ? v + 1'b1 : v;
    endfunction

    function automatic logic [WCNT_W-1:0] wrap_inc(input logic [WCNT_W-1:0] v);
        return v + 1'b1;
    endfunction

    logic [SYNC_W-1:0] sync_p0;
    logic [3:0]        sync_q;
    logic [3:0]        cand_p1;
    logic [SCNT_W-1:0] scnt_p1;
    logic [3:0]        acc_value_p2;
    logic [WCNT_W-1:0] wrap_count_p2;
    logic              accept;
    logic              wrap_hit;
    logic              overrun_evt;
    state_t            state;

    // Stage 0: per-bit synchronizer shift chain, newest sample in the low nibble
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_W-5:0], q_in};
        end
    end

    assign sync_q = sync_p0[SYNC_W-1 -: 4];

    // Stage 1: stability filter; a code must repeat STABLE_CYCLES samples in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_p1 <= '0;
            scnt_p1 <= '0;
        end else if (sync_q != cand_p1) begin
            cand_p1 <= sync_q;
            scnt_p1 <= SCNT_W'(1);
        end else begin
            scnt_p1 <= sat_inc(scnt_p1);
        end
    end

    // Fires once, on the sample that completes the run, and only for a genuinely new code
    assign accept      = (sync_q == cand_p1) && (scnt_p1 == SCNT_LAST) && (cand_p1 != acc_value_p2);
    assign wrap_hit    = accept && (cand_p1 < acc_value_p2);
    assign overrun_evt = (state == HOLD) && !out_ready && accept;

    // Stage 2: accepted value and wrap accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_value_p2  <= '0;
            wrap_count_p2 <= '0;
        end else begin
            if (accept) begin
                acc_value_p2 <= cand_p1;
            end
            if (clear) begin
                wrap_count_p2 <= '0;
            end else if (wrap_hit) begin
                wrap_count_p2 <= wrap_inc(wrap_count_p2);
            end
        end
    end

    assign ext_count = {wrap_count_p2, acc_value_p2};

    // Output stage: single-entry hold register with back-to-back reload
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_wrap  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= cand_p1;
                        out_wrap  <= wrap_hit;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (accept) begin
                            out_data <= cand_p1;
                            out_wrap <= wrap_hit;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase

            if (clear) begin
                overrun <= 1'b0;
            end else if (overrun_evt) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: directed scenarios plus randomized counter-like
// stimulus, all checked cycle by cycle against a run-length reference model.
module tb_ripple_count_capture;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 3;
    localparam int EXT_WIDTH     = 12;
    localparam int WCNT_MOD      = 1 << (EXT_WIDTH - 4);

    logic                 clk;
    logic                 reset;
    logic [3:0]           q_in;
    logic                 clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_data;
    logic                 out_wrap;
    logic [EXT_WIDTH-1:0] ext_count;
    logic                 overrun;

    ripple_count_capture #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .EXT_WIDTH    (EXT_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .q_in     (q_in),
        .clear    (clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_wrap (out_wrap),
        .ext_count(ext_count),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: delay line, run of identical samples, stream slot
    logic [3:0] m_sync[$];
    logic [3:0] m_val;
    int         m_run;
    logic [3:0] m_acc;
    int         m_wcnt;
    logic       m_v;
    logic [3:0] m_d;
    logic       m_w;
    logic       m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = {};
        repeat (SYNC_STAGES) m_sync.push_back(4'd0);
        m_val  = 4'd0;
        m_run  = 0;
        m_acc  = 4'd0;
        m_wcnt = 0;
        m_v    = 1'b0;
        m_d    = 4'd0;
        m_w    = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        int         prev_run;
        logic       acc_ev;
        logic       wrap_ev;
        logic       ovr_ev;
        if (reset) begin
            model_reset();
            return;
        end
        s = m_sync.pop_front();
        m_sync.push_back(q_in);
        prev_run = m_run;
        if (s == m_val) begin
            if (m_run < STABLE_CYCLES) m_run++;
        end else begin
            m_val    = s;
            m_run    = 1;
            prev_run = 0;
        end
        // a code is taken the moment its run completes, if it differs from the last one taken
        acc_ev  = (m_run == STABLE_CYCLES) && (prev_run < STABLE_CYCLES) && (s != m_acc);
        wrap_ev = acc_ev && (s < m_acc);
        ovr_ev  = 1'b0;
        if (acc_ev) begin
            if (!m_v || out_ready) begin
                m_v = 1'b1;
                m_d = s;
                m_w = wrap_ev;
            end else begin
                ovr_ev = 1'b1;
            end
            m_acc = s;
        end else if (m_v && out_ready) begin
            m_v = 1'b0;
        end
        if (clear) m_wcnt = 0;
        else if (wrap_ev) m_wcnt = (m_wcnt + 1) % WCNT_MOD;
        if (clear) m_ovr = 1'b0;
        else if (ovr_ev) m_ovr = 1'b1;
    endtask

    task automatic compare_all();
        logic [EXT_WIDTH-1:0] e;
        e = {(EXT_WIDTH-4)'(m_wcnt), m_acc};
        check("out_valid", 32'(out_valid), 32'(m_v));
        if (m_v) begin
            check("out_data", 32'(out_data), 32'(m_d));
            check("out_wrap", 32'(out_wrap), 32'(m_w));
        end
        check("ext_count", 32'(ext_count), 32'(e));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic step(input logic [3:0] q, input logic rdy, input logic clr, input logic rst);
        q_in      = q;
        out_ready = rdy;
        clear     = clr;
        reset     = rst;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] qv;
        int         len;
        int         cyc;
        q_in = 4'd0; out_ready = 1'b1; clear = 1'b0; reset = 1'b1;
        model_reset();

        // reset state
        step(4'd0, 1'b1, 1'b0, 1'b1);
        step(4'd0, 1'b1, 1'b0, 1'b1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ext", 32'(ext_count), 32'd0);

        // first accept lands on edge 5 and lasts one cycle
        for (int i = 1; i <= 8; i++) begin
            step(4'd3, 1'b1, 1'b0, 1'b0);
            if (i == 4) check("t1_before", 32'(out_valid), 32'd0);
            if (i == 5) begin
                check("t1_valid", 32'(out_valid), 32'd1);
                check("t1_data", 32'(out_data), 32'd3);
                check("t1_wrap", 32'(out_wrap), 32'd0);
            end
            if (i == 6) check("t1_pulse", 32'(out_valid), 32'd0);
        end
        check("t1_ext", 32'(ext_count), 32'h003);

        // short excursion to 5 is rejected
        repeat (2) step(4'd5, 1'b1, 1'b0, 1'b0);
        repeat (8) step(4'd3, 1'b1, 1'b0, 1'b0);
        check("t2_ext", 32'(ext_count), 32'h003);

        // 14 -> 15 -> 0 -> 1 with one wrap
        repeat (8) step(4'd14, 1'b1, 1'b0, 1'b0);
        repeat (8) step(4'd15, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(4'd0, 1'b1, 1'b0, 1'b0);
            if (i == 5) check("t3_wrapflag", 32'(out_wrap), 32'd1);
        end
        repeat (8) step(4'd1, 1'b1, 1'b0, 1'b0);
        check("t3_ext", 32'(ext_count), 32'h011);

        // held value refused while a newer one arrives
        repeat (8) step(4'd2, 1'b0, 1'b0, 1'b0);
        repeat (8) step(4'd4, 1'b0, 1'b0, 1'b0);
        check("t4_data", 32'(out_data), 32'd2);
        check("t4_ovr", 32'(overrun), 32'd1);
        check("t4_ext", 32'(ext_count), 32'h014);
        step(4'd4, 1'b1, 1'b0, 1'b0);
        check("t4_drain", 32'(out_valid), 32'd0);

        // clear coincides with a wrap accept
        repeat (8) step(4'd15, 1'b1, 1'b0, 1'b0);
        repeat (4) step(4'd0, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b0);
        check("t5_ext", 32'(ext_count), 32'h000);
        check("t5_ovr", 32'(overrun), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_wrap", 32'(out_wrap), 32'd1);
        repeat (3) step(4'd0, 1'b1, 1'b0, 1'b0);

        // reset while holding, then full latency again
        repeat (8) step(4'd7, 1'b0, 1'b0, 1'b0);
        check("t6_hold", 32'(out_valid), 32'd1);
        step(4'd7, 1'b0, 1'b0, 1'b1);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_ext", 32'(ext_count), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step(4'd7, 1'b1, 1'b0, 1'b0);
            if (i == 4) check("t6_lat4", 32'(out_valid), 32'd0);
            if (i == 5) check("t6_lat5", 32'(out_valid), 32'd1);
        end

        // randomized counter-like activity with glitches, backpressure, clear and reset
        cyc = 0;
        qv  = 4'd7;
        while (cyc < 3000) begin
            if ($urandom_range(0, 2) != 0) qv = qv + 4'd1;
            else qv = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                step(qv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                     1'($urandom_range(0, 299) == 0));
                cyc++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
